// File: rtl/sseg_scan_pwm_if.sv
// Bundle between the gauge/value logic and the seven-segment scanner:
// register-file write fields, global display controls and the pin-level
// segment/common-enable outputs.
// Optional build macro SSEG_SCAN_RAW_EN adds the raw pattern write fields.
interface sseg_scan_pwm_if #(
   parameter int SSEG_BITS  = 2,
   parameter int SSEG_N     = 3,
   parameter int DWELL_BITS = 4
);
   logic                  en;
   logic                  wr;
   logic [SSEG_BITS-1:0]  sel;
   logic [3:0]            val;
   logic                  sseg_en;
   logic                  sign;
   logic                  dp;
   logic                  blink;
   logic [DWELL_BITS-1:0] duty;
`ifdef SSEG_SCAN_RAW_EN
   logic                  raw;
   logic [7:0]            raw_seg;
`endif
   logic [7:0]            sseg;
   logic [SSEG_N-1:0]     oe;

   modport master (
`ifdef SSEG_SCAN_RAW_EN
      output raw, output raw_seg,
`endif
      output en, output wr, output sel, output val, output sseg_en,
      output sign, output dp, output blink, output duty,
      input  sseg, input oe
   );

   modport slave (
`ifdef SSEG_SCAN_RAW_EN
      input  raw, input raw_seg,
`endif
      input  en, input wr, input sel, input val, input sseg_en,
      input  sign, input dp, input blink, input duty,
      output sseg, output oe
   );
endinterface

// File: rtl/sseg_scan_pwm.sv
// Seven-segment scan driver with a per-module register file, global PWM
// brightness inside each dwell window and frame-synchronous blinking.
// Each entry holds {sseg_en, blink, pattern[7:0]}; outputs are registered.
// Optional build macro SSEG_SCAN_RAW_EN: writes with raw=1 store raw_seg
// verbatim instead of the val/sign/dp encoding.
module sseg_scan_pwm #(
   parameter int SSEG_BITS  = 2,
   parameter int SSEG_N     = 3,
   parameter int DWELL_BITS = 4,
   parameter int BLINK_ON   = 2,
   parameter int BLINK_OFF  = 3,
   parameter int BLINK_BITS = 3
) (
   input logic            clk,
   input logic            reset_n,
   sseg_scan_pwm_if.slave bus
);

   localparam int ENTRY_W = 10;
   localparam int EN_BIT  = 9;
   localparam int BLK_BIT = 8;

   // Hex/BCD to segments (bit0=a .. bit6=g); sign forces a lone minus bar,
   // dp is ORed into bit7 on top of either.
   function automatic logic [7:0] seg_encode(input logic [3:0] v,
                                             input logic       sgn,
                                             input logic       pnt);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         default: g = 7'h71;
      endcase
      if (sgn) g = 7'h40;
      return {pnt, g};
   endfunction

   logic [SSEG_BITS-1:0]  s_q, s_d;
   logic [DWELL_BITS-1:0] d_q, d_d;
   logic [BLINK_BITS-1:0] bc_q, bc_d;
   logic [ENTRY_W-1:0]    entry_q [SSEG_N];
   logic [ENTRY_W-1:0]    entry_d [SSEG_N];
   logic [7:0]            sseg_q, sseg_d;
   logic [SSEG_N-1:0]     oe_q, oe_d;

   logic [7:0]            wr_pat;
   logic [ENTRY_W-1:0]    wr_entry;
   logic [ENTRY_W-1:0]    cur_entry;
   logic                  frame_end;
   logic                  blink_lit;
   logic                  lit;

   // Build the entry a write would store (encoded digit or raw pattern).
   always_comb begin
      wr_pat = seg_encode(bus.val, bus.sign, bus.dp);
`ifdef SSEG_SCAN_RAW_EN
      if (bus.raw) wr_pat = bus.raw_seg;
`endif
      wr_entry = {bus.sseg_en, bus.blink, wr_pat};
   end

   // Free-running dwell/slot/blink counters; they ignore en so that the
   // display resumes in phase when en returns.
   always_comb begin
      d_d       = d_q + 1'b1;
      s_d       = s_q;
      bc_d      = bc_q;
      frame_end = 1'b0;
      if (d_q == '1) begin
         if (int'(s_q) == SSEG_N - 1) begin
            s_d       = '0;
            frame_end = 1'b1;
         end else begin
            s_d = s_q + 1'b1;
         end
      end
      if (frame_end) begin
         bc_d = (int'(bc_q) == BLINK_ON + BLINK_OFF - 1) ? '0 : bc_q + 1'b1;
      end
   end

   // Register-file update; a sel beyond the last module matches no entry.
   always_comb begin
      for (int i = 0; i < SSEG_N; i++) begin
         entry_d[i] = entry_q[i];
         if (bus.wr && (int'(bus.sel) == i)) entry_d[i] = wr_entry;
      end
   end

   // Lit decision for the slot/dwell being evaluated this clock. d < duty
   // also guarantees the last clock of every slot is dark (ghosting guard).
   always_comb begin
      cur_entry = '0;
      oe_d      = '0;
      for (int i = 0; i < SSEG_N; i++) begin
         if (int'(s_q) == i) cur_entry = entry_q[i];
      end
      blink_lit = (int'(bc_q) < BLINK_ON);
      lit = bus.en && cur_entry[EN_BIT] && (d_q < bus.duty) &&
            (!cur_entry[BLK_BIT] || blink_lit);
      sseg_d = lit ? cur_entry[7:0] : 8'h00;
      for (int i = 0; i < SSEG_N; i++) begin
         if (lit && (int'(s_q) == i)) oe_d[i] = 1'b1;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s_q    <= '0;
         d_q    <= '0;
         bc_q   <= '0;
         sseg_q <= '0;
         oe_q   <= '0;
         for (int i = 0; i < SSEG_N; i++) entry_q[i] <= '0;
      end else begin
         s_q    <= s_d;
         d_q    <= d_d;
         bc_q   <= bc_d;
         sseg_q <= sseg_d;
         oe_q   <= oe_d;
         for (int i = 0; i < SSEG_N; i++) entry_q[i] <= entry_d[i];
      end
   end

   assign bus.sseg = sseg_q;
   assign bus.oe   = oe_q;

endmodule
